// File: rtl/mem_responder_pkg.sv
// Shared types and sizing constants for the mem_responder slice.
package mem_responder_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x 32 word storage: synchronous per-lane write, combinational read.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder with valid/ready request and response.
// Optional byte-lane store enables via MEM_RESPONDER_BYTE_WRITE_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        pend_rdata_q;
  logic               pend_err_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic               accept;
  logic               acc_err;
  logic [31:0]        arr_rdata;
  logic [31:0]        acc_rdata;
  logic               wr_en;
  logic [WORD_BYTES-1:0] wr_be;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready && !reset;
  assign acc_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
  assign acc_rdata = (req_we || acc_err) ? 32'd0 : arr_rdata;
  // Store commits on the accept edge; a bad address or reset suppresses it.
  assign wr_en     = accept && req_we && !acc_err;

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
  assign wr_be = req_be;
`else
  assign wr_be = {WORD_BYTES{1'b1}};
`endif

  mem_responder_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .be_i    (wr_be),
    .addr_i  (req_addr[AW+1:2]),
    .wdata_i (req_wdata),
    .rdata_o (arr_rdata)
  );

  // Control FSM with registered response outputs (zero outside RESP).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= acc_rdata;
              rsp_err_q   <= acc_err;
            end else begin
              state_q      <= WAIT;
              cnt_q        <= CNT_W'(LATENCY - 2);
              pend_rdata_q <= acc_rdata;
              pend_err_q   <= acc_err;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pend_rdata_q;
            rsp_err_q   <= pend_err_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 and LATENCY=1 instances).
// Byte-enable cases run when MEM_RESPONDER_BYTE_WRITE_EN is defined.
module tb_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_we1, rsp_ready1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_we    (req_we1),
    .req_addr  (req_addr1),
    .req_wdata (req_wdata1),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    .req_be    (req_be1),
`endif
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; hold = extra cycles rsp_ready stays low.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int hold, input logic early_ready);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    check({tag, ".req_ready_pre"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = early_ready;
    for (int i = 1; i < int'(LAT); i++) begin
      check({tag, ".valid_wait"}, 32'(rsp_valid), 32'd0);
      check({tag, ".ready_wait"}, 32'(req_ready), 32'd0);
      check({tag, ".rdata_wait"}, rsp_rdata, 32'd0);
      @(posedge clk); #1;
    end
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".err"},   32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, ".hold_err"},   32'(rsp_err), 32'(exp_err));
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".post_rdata"}, rsp_rdata, 32'd0);
  endtask

  // One transaction on the LATENCY=1 instance: response visible right after accept.
  task automatic do_req1(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp_rd);
    req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_wdata1 = wd; req_be1 = be;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    check({tag, ".valid"}, 32'(rsp_valid1), 32'd1);
    check({tag, ".rdata"}, rsp_rdata1, exp_rd);
    check({tag, ".err"},   32'(rsp_err1), 32'd0);
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready1 = 1'b0;
    check({tag, ".post_valid"}, 32'(rsp_valid1), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 4'hF; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = 4'hF; rsp_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err",   32'(rsp_err), 32'd0);

    do_req("st08",  1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 32'd0,        1'b0, 0, 1'b0);
    do_req("ld08",  1'b0, 32'h08,  32'd0,        4'hF, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    do_req("st0a",  1'b1, 32'h0A,  32'h12345678, 4'hF, 32'd0,        1'b1, 0, 1'b0);
    do_req("ld08b", 1'b0, 32'h08,  32'd0,        4'hF, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    do_req("ld100", 1'b0, 32'h100, 32'd0,        4'hF, 32'd0,        1'b1, 0, 1'b0);
    do_req("stFC",  1'b1, 32'hFC,  32'h0BADF00D, 4'hF, 32'd0,        1'b0, 0, 1'b0);
    do_req("ldFC",  1'b0, 32'hFC,  32'd0,        4'hF, 32'h0BADF00D, 1'b0, 0, 1'b1);
    do_req("hold",  1'b0, 32'h08,  32'd0,        4'hF, 32'hDEADBEEF, 1'b0, 5, 1'b0);
    do_req("st0c",  1'b1, 32'h0C,  32'hAAAA5555, 4'hF, 32'd0,        1'b0, 0, 1'b0);

    // Reset in WAIT discards the pending response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h08;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstwait.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstwait.req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rstwait.no_rsp", 32'(rsp_valid), 32'd0);

    // Reset coincident with a store request: no accept, no write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0C; req_wdata = 32'h99999999;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    check("rstreq.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstreq.req_ready", 32'(req_ready), 32'd1);
    do_req("ld0c", 1'b0, 32'h0C, 32'd0, 4'hF, 32'hAAAA5555, 1'b0, 0, 1'b0);
    do_req("ld08c", 1'b0, 32'h08, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 0, 1'b0);

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    do_req("be_st", 1'b1, 32'h08, 32'h11223344, 4'b0011, 32'd0,        1'b0, 0, 1'b0);
    do_req("be_ld", 1'b0, 32'h08, 32'd0,        4'b0000, 32'hDEAD3344, 1'b0, 0, 1'b0);
    do_req("be_0",  1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000, 32'd0,        1'b0, 0, 1'b0);
    do_req("be_ld2",1'b0, 32'h08, 32'd0,        4'b1111, 32'hDEAD3344, 1'b0, 0, 1'b0);
`endif

    do_req1("l1_st", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'd0);
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    do_req1("l1_be", 1'b1, 32'h08, 32'h11223344, 4'b0011, 32'd0);
    do_req1("l1_ld", 1'b0, 32'h08, 32'd0, 4'hF, 32'hDEAD3344);
`else
    do_req1("l1_ld", 1'b0, 32'h08, 32'd0, 4'hF, 32'hDEADBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
